// File: rtl/bfly_pkg.sv
// rtl/bfly_pkg.sv - shared defaults, width helpers, FSM state type and pair-index function
package bfly_pkg;

  localparam int BU_PAR_DEF  = 8;
  localparam int MAX_LEN_DEF = 4096;

  function automatic int idx_w_f(input int max_len);
    return $clog2(max_len);
  endfunction

  function automatic int log_w_f(input int max_len);
    return $clog2($clog2(max_len) + 1);
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Insert a zero bit at position s of pair ordinal p to get the lower index.
  function automatic logic [31:0] pair_lo(input logic [31:0] p, input logic [4:0] s);
    return ((p >> s) << (s + 5'd1)) | (p & ((32'd1 << s) - 32'd1));
  endfunction

endpackage

// File: rtl/bfly_pair_addr.sv
// rtl/bfly_pair_addr.sv - one butterfly lane: lower/upper index (and twiddle address with BFLY_TWIDDLE_EN)
module bfly_pair_addr
  import bfly_pkg::*;
#(
  parameter int IDX_W = 12,
  parameter int LOG_W = 4
) (
  input  logic [IDX_W-1:0] p_i,
  input  logic [LOG_W-1:0] s_i,
`ifdef BFLY_TWIDDLE_EN
  output logic [IDX_W-1:0] tw_o,
`endif
  output logic [IDX_W-1:0] lo_o,
  output logic [IDX_W-1:0] hi_o
);

  assign lo_o = IDX_W'(pair_lo(32'(p_i), 5'(s_i)));
  assign hi_o = lo_o + (IDX_W'(1) << s_i);

`ifdef BFLY_TWIDDLE_EN
  // Scale the in-group offset onto a full MAX_LEN-point twiddle table.
  assign tw_o = IDX_W'((32'(p_i) & ((32'd1 << s_i) - 32'd1)) << (IDX_W - 1 - int'(s_i)));
`endif

endmodule

// File: rtl/butterfly_addr_gen_v2.sv
// rtl/butterfly_addr_gen_v2.sv - radix-2 butterfly index generator, BU_PAR lanes, DIF/DIT, valid/ready
// Optional twiddle address output enabled by BFLY_TWIDDLE_EN.
module butterfly_addr_gen_v2
  import bfly_pkg::*;
#(
  parameter  int BU_PAR  = BU_PAR_DEF,
  parameter  int MAX_LEN = MAX_LEN_DEF,
  localparam int IDX_W   = idx_w_f(MAX_LEN),
  localparam int LOG_W   = log_w_f(MAX_LEN)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [LOG_W-1:0]            log2_len,
  input  logic                        dir,
  output logic                        busy,
  output logic                        out_vld,
  input  logic                        out_rdy,
  output logic [BU_PAR/2*IDX_W-1:0]   out_lo_idx,
  output logic [BU_PAR/2*IDX_W-1:0]   out_hi_idx,
`ifdef BFLY_TWIDDLE_EN
  output logic [BU_PAR/2*IDX_W-1:0]   out_tw_idx,
`endif
  output logic [LOG_W-1:0]            out_stage,
  output logic                        out_stage_last,
  output logic                        out_last,
  output logic                        done,
  output logic                        err
);

  localparam int LANES   = BU_PAR / 2;
  localparam int LOG_BU  = $clog2(BU_PAR);
  localparam int LOG_MAX = $clog2(MAX_LEN);
  localparam logic [LOG_W-1:0] LEN_MIN = LOG_W'(LOG_BU);
  localparam logic [LOG_W-1:0] LEN_MAX = LOG_W'(LOG_MAX);
  localparam logic [IDX_W-1:0] K_STEP  = IDX_W'(LANES);

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        k_q, k_d;
  logic [LOG_W-1:0]        s_q, s_d;
  logic [LOG_W-1:0]        len_q, len_d;
  logic                    dir_q, dir_d;
  logic                    busy_q, busy_d;
  logic                    vld_q, vld_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;
  logic                    load;

  logic [LANES*IDX_W-1:0]  lo_q, lo_d;
  logic [LANES*IDX_W-1:0]  hi_q, hi_d;
  logic [LOG_W-1:0]        stage_q;
  logic                    stage_last_q, stage_last_d;
  logic                    last_q, last_d;
  logic [IDX_W-1:0]        k_end;

  // Flags describe the beat about to be loaded, i.e. the next-state counters.
  assign k_end        = (IDX_W'(1) << (len_d - LOG_W'(1))) - K_STEP;
  assign stage_last_d = (k_d == k_end);
  assign last_d       = stage_last_d && (dir_d ? (s_d == len_d - LOG_W'(1)) : (s_d == '0));

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    s_d     = s_q;
    len_d   = len_q;
    dir_d   = dir_q;
    busy_d  = busy_q;
    vld_d   = vld_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    load    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (log2_len < LEN_MIN || log2_len > LEN_MAX) begin
            err_d = 1'b1;
          end else begin
            len_d   = log2_len;
            dir_d   = dir;
            k_d     = '0;
            s_d     = dir ? '0 : log2_len - LOG_W'(1);
            busy_d  = 1'b1;
            vld_d   = 1'b1;
            load    = 1'b1;
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (vld_q && out_rdy) begin
          if (last_q) begin
            vld_d   = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            load = 1'b1;
            if (stage_last_q) begin
              k_d = '0;
              s_d = dir_q ? s_q + LOG_W'(1) : s_q - LOG_W'(1);
            end else begin
              k_d = k_q + K_STEP;
            end
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef BFLY_TWIDDLE_EN
  logic [LANES*IDX_W-1:0] tw_q, tw_d;
`endif

  for (genvar j = 0; j < LANES; j++) begin : g_lane
    bfly_pair_addr #(
      .IDX_W (IDX_W),
      .LOG_W (LOG_W)
    ) u_pair (
      .p_i  (k_d + IDX_W'(j)),
      .s_i  (s_d),
`ifdef BFLY_TWIDDLE_EN
      .tw_o (tw_d[j*IDX_W +: IDX_W]),
`endif
      .lo_o (lo_d[j*IDX_W +: IDX_W]),
      .hi_o (hi_d[j*IDX_W +: IDX_W])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      k_q          <= '0;
      s_q          <= '0;
      len_q        <= '0;
      dir_q        <= 1'b0;
      busy_q       <= 1'b0;
      vld_q        <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      lo_q         <= '0;
      hi_q         <= '0;
      stage_q      <= '0;
      stage_last_q <= 1'b0;
      last_q       <= 1'b0;
`ifdef BFLY_TWIDDLE_EN
      tw_q         <= '0;
`endif
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      s_q     <= s_d;
      len_q   <= len_d;
      dir_q   <= dir_d;
      busy_q  <= busy_d;
      vld_q   <= vld_d;
      done_q  <= done_d;
      err_q   <= err_d;
      if (load) begin
        lo_q         <= lo_d;
        hi_q         <= hi_d;
        stage_q      <= s_d;
        stage_last_q <= stage_last_d;
        last_q       <= last_d;
`ifdef BFLY_TWIDDLE_EN
        tw_q         <= tw_d;
`endif
      end
    end
  end

  assign busy           = busy_q;
  assign out_vld        = vld_q;
  assign out_lo_idx     = lo_q;
  assign out_hi_idx     = hi_q;
  assign out_stage      = stage_q;
  assign out_stage_last = stage_last_q;
  assign out_last       = last_q;
  assign done           = done_q;
  assign err            = err_q;
`ifdef BFLY_TWIDDLE_EN
  assign out_tw_idx     = tw_q;
`endif

endmodule

// File: tb/tb_butterfly_addr_gen_v2.sv
// tb/tb_butterfly_addr_gen_v2.sv - scoreboard bench for butterfly_addr_gen_v2 (BU_PAR=8, MAX_LEN=4096)
module tb_butterfly_addr_gen_v2;

  localparam int IDX_W = 12;
  localparam int LOG_W = 4;
  localparam int LANES = 4;
  localparam int VW    = LANES * IDX_W;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [LOG_W-1:0] log2_len = '0;
  logic             dir = 1'b0;
  logic             busy, out_vld, out_stage_last, out_last, done, err;
  logic             out_rdy = 1'b1;
  logic [VW-1:0]    out_lo_idx, out_hi_idx;
  logic [LOG_W-1:0] out_stage;
`ifdef BFLY_TWIDDLE_EN
  logic [VW-1:0]    out_tw_idx;
`endif

  butterfly_addr_gen_v2 dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .log2_len       (log2_len),
    .dir            (dir),
    .busy           (busy),
    .out_vld        (out_vld),
    .out_rdy        (out_rdy),
    .out_lo_idx     (out_lo_idx),
    .out_hi_idx     (out_hi_idx),
`ifdef BFLY_TWIDDLE_EN
    .out_tw_idx     (out_tw_idx),
`endif
    .out_stage      (out_stage),
    .out_stage_last (out_stage_last),
    .out_last       (out_last),
    .done           (done),
    .err            (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [VW-1:0] lo;
    logic [VW-1:0] hi;
    int            stage;
    bit            sl;
    bit            last;
  } beat_t;

  beat_t sb[$];
  int total = 0;
  int bad = 0;
  int hs_count = 0;
  int done_cnt = 0;
  bit pend_done = 0;
  bit stall_en = 0;
  int stall_n = 0;
  bit stall_prev = 0;
  logic [VW-1:0] snap_lo, snap_hi;
  logic [LOG_W-1:0] snap_st;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Lower index: keep bits below s, shift bits at/above s up by one position.
  task automatic push_run(input int len, input bit d);
    int n;
    int s;
    beat_t b;
    n = 1 << len;
    for (int st = 0; st < len; st++) begin
      s = d ? st : len - 1 - st;
      for (int k = 0; k < n / 2; k += LANES) begin
        for (int j = 0; j < LANES; j++) begin
          int p;
          int lo;
          p  = k + j;
          lo = (p / (1 << s)) * (1 << (s + 1)) + (p % (1 << s));
          b.lo[j*IDX_W +: IDX_W] = IDX_W'(lo);
          b.hi[j*IDX_W +: IDX_W] = IDX_W'(lo + (1 << s));
        end
        b.stage = s;
        b.sl    = (k == n / 2 - LANES);
        b.last  = b.sl && (st == len - 1);
        sb.push_back(b);
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 0;
    end else begin
      if (done) done_cnt++;
      if (pend_done) begin
        chk("done_pulse", 64'(done), 64'd1);
        pend_done = 0;
      end
      if (stall_prev) begin
        chk("stall_vld", 64'(out_vld), 64'd1);
        chk("stall_lo", 64'(out_lo_idx), 64'(snap_lo));
        chk("stall_hi", 64'(out_hi_idx), 64'(snap_hi));
        chk("stall_stage", 64'(out_stage), 64'(snap_st));
      end
      stall_prev = out_vld && !out_rdy;
      snap_lo = out_lo_idx;
      snap_hi = out_hi_idx;
      snap_st = out_stage;
      if (out_vld && out_rdy) begin
        if (sb.size() == 0) begin
          chk("extra_beat", 64'd1, 64'd0);
        end else begin
          beat_t e;
          e = sb.pop_front();
          chk("lo", 64'(out_lo_idx), 64'(e.lo));
          chk("hi", 64'(out_hi_idx), 64'(e.hi));
          chk("stage", 64'(out_stage), 64'(e.stage));
          chk("stage_last", 64'(out_stage_last), 64'(e.sl));
          chk("last", 64'(out_last), 64'(e.last));
        end
        hs_count++;
        pend_done = out_last;
      end
    end
  end

  // Hold out_rdy low for three cycles while the third beat is presented.
  always begin
    @(posedge clk);
    #1;
    if (stall_en && hs_count == 2 && stall_n < 3) begin
      out_rdy = 1'b0;
      stall_n++;
    end else begin
      out_rdy = 1'b1;
    end
  end

  task automatic do_run(input int len, input bit d, input bit stall, input bit ign);
    int base;
    int dc;
    int beats;
    int cyc;
    beats = len * (1 << len) / (2 * LANES);
    push_run(len, d);
    hs_count = 0;
    base = 0;
    dc = done_cnt;
    stall_n = 0;
    stall_en = stall;
    @(posedge clk);
    #1;
    log2_len = LOG_W'(len);
    dir = d;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("busy_on", 64'(busy), 64'd1);
    cyc = 0;
    if (ign) begin
      start = 1'b1;
      log2_len = LOG_W'(2);
      @(posedge clk);
      #1;
      start = 1'b0;
      cyc = 1;
      @(negedge clk);
      chk("ign_err", 64'(err), 64'd0);
    end
    while (busy === 1'b1 && cyc < 10000) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("run_timeout", 64'(cyc < 10000), 64'd1);
    chk("cycles", 64'(cyc), 64'(beats + (stall ? 3 : 0)));
    chk("vld_off", 64'(out_vld), 64'd0);
    @(negedge clk);
    @(posedge clk);
    #1;
    chk("done_cnt", 64'(done_cnt - dc), 64'd1);
    chk("beats", 64'(hs_count - base), 64'(beats));
    chk("sb_drained", 64'(sb.size()), 64'd0);
    stall_en = 0;
  endtask

  task automatic bad_start(input int len);
    @(posedge clk);
    #1;
    log2_len = LOG_W'(len);
    dir = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    chk("err_pulse", 64'(err), 64'd1);
    chk("err_busy", 64'(busy), 64'd0);
    chk("err_vld", 64'(out_vld), 64'd0);
    @(negedge clk);
    chk("err_clear", 64'(err), 64'd0);
    chk("err_vld2", 64'(out_vld), 64'd0);
  endtask

  task automatic abort_run();
    int cyc;
    int dc;
    push_run(5, 1'b0);
    hs_count = 0;
    dc = done_cnt;
    @(posedge clk);
    #1;
    log2_len = LOG_W'(5);
    dir = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    cyc = 0;
    while (hs_count < 7 && cyc < 1000) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("abort_timeout", 64'(cyc < 1000), 64'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    pend_done = 0;
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_vld", 64'(out_vld), 64'd0);
    chk("rst_lo", 64'(out_lo_idx), 64'd0);
    chk("rst_hi", 64'(out_hi_idx), 64'd0);
    chk("rst_stage", 64'(out_stage), 64'd0);
    chk("rst_flags", 64'({out_stage_last, out_last, done, err}), 64'd0);
    repeat (3) @(negedge clk);
    chk("rst_no_done", 64'(done_cnt - dc), 64'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("init_busy", 64'(busy), 64'd0);
    chk("init_vld", 64'(out_vld), 64'd0);
    chk("init_lo", 64'(out_lo_idx), 64'd0);
    chk("init_flags", 64'({out_stage_last, out_last, done, err}), 64'd0);

    do_run(5, 1'b0, 1'b0, 1'b0);
    do_run(4, 1'b1, 1'b0, 1'b0);
    do_run(5, 1'b0, 1'b1, 1'b0);
    bad_start(2);
    bad_start(13);
    do_run(3, 1'b0, 1'b0, 1'b1);
    do_run(3, 1'b1, 1'b0, 1'b0);
    abort_run();
    do_run(5, 1'b1, 1'b0, 1'b0);
    do_run(12, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/butterfly_addr_gen_v2.md
Name: butterfly_addr_gen_v2

Overview:
Parametrised successor to the fixed 8-lane butterfly index generator. It emits, per beat, BU_PAR/2 butterfly pairs (lower/upper index) for every stage of a radix-2 transform of runtime length N = 2^log2_len. It supports any power-of-two lane count, both stage orders (DIF: stride descending; DIT: stride ascending), and valid/ready backpressure. It sits between the NPU sequencer and the butterfly-unit operand buffers.

Parameters:
BU_PAR, 8, butterfly lanes (indices per beat); power of two, >=2
MAX_LEN, 4096, largest supported N; power of two, >= BU_PAR
IDX_W, $clog2(MAX_LEN), index width (derived, not overridable)
LOG_W, $clog2($clog2(MAX_LEN)+1), width of stage/log-length fields (derived)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  request a new transform; sampled only in IDLE
log2_len  in  LOG_W  log2(N), sampled with start
dir  in  1  0 = DIF (stage log2_len-1 down to 0), 1 = DIT (stage 0 up to log2_len-1), sampled with start
busy  out  1  high from accepted start until the last beat handshakes
out_vld  out  1  beat valid
out_rdy  in  1  downstream accepts beat
out_lo_idx  out  BU_PAR/2*IDX_W  lane j lower index at bits [j*IDX_W +: IDX_W]
out_hi_idx  out  BU_PAR/2*IDX_W  lane j upper index (= lo + stride)
out_stage  out  LOG_W  stage s of current beat (stride = 2^s)
out_stage_last  out  1  last beat of current stage
out_last  out  1  last beat of whole transform
done  out  1  one-cycle pulse the cycle after final handshake
err  out  1  one-cycle pulse on rejected start

Behaviour:
- Reset: all outputs 0; state IDLE; internal counters 0. Reset mid-transform aborts immediately; no done is issued.
- States: IDLE -> RUN -> DONE -> IDLE.
- IDLE + start:
  - If log2_len < log2(BU_PAR) or log2_len > log2(MAX_LEN): err=1 for one cycle, remain IDLE.
  - Otherwise latch the parameters, set k=0, set s to log2_len-1 (dir=0) or 0 (dir=1), busy=1, go to RUN.
- RUN: out_vld=1 starting the cycle after start is accepted.
  - Pair ordinal k covers 0..N/2-1 in steps of BU_PAR/2.
  - Lane j: p = k+j; lo = ((p>>s)<<(s+1)) | (p & (2^s-1)); hi = lo + 2^s.
  - Arithmetic is unsigned IDX_W; no wrap occurs for legal N.
- Handshake:
  - Beat advances only when out_vld && out_rdy.
  - While out_rdy=0, all out_* fields hold stable.
  - out_vld never drops in RUN until the final handshake.
- Stage advance: out_stage_last=1 when k = N/2-BU_PAR/2. On its handshake, k resets to 0 and s steps by -1 (dir=0) or +1 (dir=1).
- out_last = out_stage_last on the final stage. On its handshake: out_vld=0, busy=0, go to DONE.
- DONE: done=1 for one cycle, then IDLE. A new start is accepted in the following cycle.
- start outside IDLE is ignored (no err).
- Beats per stage = N/BU_PAR; total beats = log2_len*N/BU_PAR; with out_rdy held high, no bubbles.
- Degenerate case: log2_len = log2(BU_PAR) gives one beat per stage.

Optional Feature:
BFLY_TWIDDLE_EN:
- Defined: adds output out_tw_idx (BU_PAR/2*IDX_W). Lane j value = (p & (2^s-1)) << (log2(MAX_LEN)-1-s), which is the twiddle ROM address for a MAX_LEN-point table. It is registered and held under the same handshake as the indices.
- Undefined: the port is absent and no twiddle logic is built.

Decomposition:
- Package bfly_pkg: MAX_LEN, BU_PAR defaults; derived IDX_W/LOG_W functions; state enum typedef (IDLE/RUN/DONE); pure function pair_lo(p, s).
- One sub-module, bfly_pair_addr: combinational, one lane; inputs (p, s); outputs lo, hi, and optionally tw. It is instantiated BU_PAR/2 times in a generate loop.
- The top level holds the FSM, k/s counters and the output register stage.

Test Plan:
- N=32 (log2_len=5), BU_PAR=8, dir=0, out_rdy=1 -> first beat s=4, lo={0,1,2,3}, hi={16,17,18,19}; 4 beats/stage, 20 beats total, out_last on beat 20, done the next cycle.
- Same run: stage 1 first beat lo={0,1,4,5}, hi={2,3,6,7}; stage 0 first beat lo={0,2,4,6}, hi={1,3,5,7}.
- N=16, dir=1 -> stages emitted 0,1,2,3; 2 beats each; stage 3 beat 0 lo={0,1,2,3}, hi={8,9,10,11}.
- Backpressure: out_rdy=0 for 3 cycles on beat 2 -> fields stable, out_vld stays 1, no beat lost or duplicated (scoreboard matches 20 beats).
- log2_len=2 with BU_PAR=8, or log2_len=13 with MAX_LEN=4096 -> err pulse, out_vld stays 0, busy stays 0; start during RUN is ignored.
- rst asserted at beat 7 -> next cycle all outputs 0, no done; a fresh start then runs a complete, correct transform.
